reaction_timer: RTL and testbench

REACTION_TIMER -- requirements
Module: reaction_timer

---
 rtl/reaction_timer_if.sv | 27 ++
 rtl/reaction_timer.sv | 147 ++++++++++++++
 tb/tb_reaction_timer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/reaction_timer_if.sv
// Reaction timer I/O bundle.
// Buttons (start, stop) flow toward the timer; the go light, foul flag, four BCD
// millisecond digits (bcd0 = ones .. bcd3 = thousands) and the per-digit decoder
// enables (digen bit n drives the decoder of bcdn) flow back out.
//   master : drives buttons, observes display (board / testbench side)
//   slave  : the timer itself
interface reaction_timer_if;
  logic       start;
  logic       stop;
  logic       led;
  logic       foul;
  logic [3:0] bcd0;
  logic [3:0] bcd1;
  logic [3:0] bcd2;
  logic [3:0] bcd3;
  logic [3:0] digen;

  modport master (
    output start, stop,
    input  led, foul, bcd0, bcd1, bcd2, bcd3, digen
  );

  modport slave (
    input  start, stop,
    output led, foul, bcd0, bcd1, bcd2, bcd3, digen
  );
endinterface

// File: rtl/reaction_timer.sv
// Human reaction timer.
// A start press arms a pseudo-random 1024..3071 ms wait, after which the go light
// turns on and a 4-digit BCD millisecond count runs until the stop press (or
// saturates at 9999). A stop press during the wait is a foul.
// Ports:
//   clk   : single clock, all state on rising edge
//   reset : asynchronous, active-high
//   io    : reaction_timer_if.slave (start/stop in; led, foul, bcd0..3, digen out)
// Parameters:
//   TICKDIV : clock cycles per 1 ms tick
//   SEED    : non-zero LFSR reset value
module reaction_timer #(
  parameter int unsigned TICKDIV = 50000,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input logic             clk,
  input logic             reset,
  reaction_timer_if.slave io
);

  localparam int unsigned PW = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
  localparam logic [PW-1:0] PresLast = PW'(TICKDIV - 1);

  typedef enum logic [2:0] {StIdle, StWait, StGo, StDone, StFoul} state_e;

  state_e          state_q, state_d;
  logic            start_prev_q, start_prev_d;
  logic            stop_prev_q, stop_prev_d;
  logic [PW-1:0]   pres_q, pres_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [11:0]     delay_q, delay_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic [3:0][3:0] dig_inc;
  logic            led_q, led_d;
  logic            foul_q, foul_d;
  logic [3:0]      digen_q, digen_d;

  logic start_edge, stop_edge, tick, dig_sat, entering;

  assign start_edge = io.start & ~start_prev_q;
  assign stop_edge  = io.stop & ~stop_prev_q;
  assign tick       = (pres_q == PresLast);
  assign dig_sat    = (dig_q == 16'h9999);

  // Decimal increment with ripple carry across the four digits.
  always_comb begin
    logic carry;
    dig_inc = dig_q;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (dig_q[i] == 4'd9) begin
          dig_inc[i] = 4'd0;
        end else begin
          dig_inc[i] = dig_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    delay_d      = delay_q;
    dig_d        = dig_q;
    start_prev_d = io.start;
    stop_prev_d  = io.stop;
    // Fibonacci LFSR, taps 16,14,13,11; a non-zero seed never reaches zero.
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    unique case (state_q)
      StIdle, StDone, StFoul: begin
        if (start_edge) state_d = StWait;
      end
      StWait: begin
        // Stop has priority over a tick landing in the same cycle.
        if (stop_edge) begin
          state_d = StFoul;
        end else if (tick) begin
          if (delay_q == 12'd1) state_d = StGo;
          else                  delay_d = delay_q - 12'd1;
        end
      end
      StGo: begin
        // A stop coinciding with a tick freezes the count without that tick.
        if (stop_edge) begin
          state_d = StDone;
        end else if (tick) begin
          if (dig_sat) state_d = StDone;
          else         dig_d   = dig_inc;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StWait && state_q != StWait) begin
      delay_d = 12'd1024 + {1'b0, lfsr_q[10:0]};
      dig_d   = '0;
    end
    if (state_d == StFoul) dig_d = '0;

    // Prescaler restarts on WAIT/GO entry so the first tick lands TICKDIV cycles later.
    entering = (state_d != state_q) && (state_d == StWait || state_d == StGo);
    if (entering || tick) pres_d = '0;
    else                  pres_d = pres_q + PW'(1);

    // Outputs are decoded from the next state and registered.
    led_d   = (state_d == StGo);
    foul_d  = (state_d == StFoul);
    digen_d = (state_d == StWait) ? 4'b0000 : 4'b1111;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      pres_q       <= '0;
      lfsr_q       <= SEED;
      delay_q      <= '0;
      dig_q        <= '0;
      led_q        <= 1'b0;
      foul_q       <= 1'b0;
      digen_q      <= 4'b1111;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      stop_prev_q  <= stop_prev_d;
      pres_q       <= pres_d;
      lfsr_q       <= lfsr_d;
      delay_q      <= delay_d;
      dig_q        <= dig_d;
      led_q        <= led_d;
      foul_q       <= foul_d;
      digen_q      <= digen_d;
    end
  end

  assign io.led   = led_q;
  assign io.foul  = foul_q;
  assign io.digen = digen_q;
  assign io.bcd0  = dig_q[0];
  assign io.bcd1  = dig_q[1];
  assign io.bcd2  = dig_q[2];
  assign io.bcd3  = dig_q[3];

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer with a 4-cycle millisecond tick.
// The reference model works in whole milliseconds: the wait length is derived from
// the LFSR value at the arming edge, GO lasts a computed number of cycles, and the
// expected display is the integer count split into decimal digits.
module tb_reaction_timer;

  localparam int unsigned TickDiv = 4;
  localparam logic [15:0] Seed    = 16'hACE1;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  reaction_timer_if bus ();

  reaction_timer #(
    .TICKDIV (TickDiv),
    .SEED    (Seed)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  // Reference LFSR value: what the timer will use at the next clock edge.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [15:0] model_lfsr;
  always @(posedge clk or posedge reset) begin
    if (reset) model_lfsr <= Seed;
    else       model_lfsr <= lfsr_step(model_lfsr);
  end

  function automatic int delay_of(input logic [15:0] s);
    return 1024 + int'(s & 16'h07FF);
  endfunction

  // Count shown after a stop edge sampled s cycles into GO: ticks at 4,8,.. strictly
  // before s, capped at 9999.
  function automatic int cnt_at_stop(input int s);
    int c;
    c = (s - 1) / int'(TickDiv);
    return (c > 9999) ? 9999 : c;
  endfunction

  function automatic logic [31:0] exp_out(input bit led, input bit foul,
                                          input logic [3:0] digen, input int cnt);
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'((cnt / 1000) % 10);
    d2 = 4'((cnt / 100) % 10);
    d1 = 4'((cnt / 10) % 10);
    d0 = 4'(cnt % 10);
    return {10'd0, led, foul, digen, d3, d2, d1, d0};
  endfunction

  function automatic logic [31:0] obs();
    return {10'd0, bus.led, bus.foul, bus.digen, bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits from WAIT entry for the go light; d is the model's delay in ms.
  task automatic wait_led(input int d, output int n);
    n = 0;
    while (bus.led !== 1'b1 && n < 13000) begin
      cyc(1);
      n++;
    end
    chk("led_rise_cycles", 32'(n), 32'(d * int'(TickDiv)));
    chk("go_entry", obs(), exp_out(1, 0, 4'hF, 0));
  endtask

  // From GO offset 0, presents a stop edge at GO offset s.
  task automatic stop_at(input int s);
    cyc(s - 1);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
  endtask

  int d1, d, n, s, r;

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    reset     = 1'b0;

    // Asynchronous reset between clock edges.
    #2 reset = 1'b1;
    #1;
    chk("reset_async", obs(), exp_out(0, 0, 4'hF, 0));

    // Round A: start held through reset release arms on the first edge.
    bus.start = 1'b1;
    cyc(2);
    chk("reset_held", obs(), exp_out(0, 0, 4'hF, 0));
    reset = 1'b0;
    d1 = delay_of(model_lfsr);
    cyc(1);
    bus.start = 1'b0;
    chk("a_wait_entry", obs(), exp_out(0, 0, 4'h0, 0));
    wait_led(d1, n);
    chk("a_led_window", 32'((n >= 4096 && n <= 12284) ? 1 : 0), 32'd1);
    stop_at(1001);
    chk("a_done_0250", obs(), exp_out(0, 0, 4'hF, cnt_at_stop(1001)));

    // Stop ignored in DONE.
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    cyc(1);
    chk("done_stop_ignored", obs(), exp_out(0, 0, 4'hF, 250));

    // Start and stop together in DONE: new round.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("done_both_to_wait", obs(), exp_out(0, 0, 4'h0, 0));

    // Start ignored in WAIT, then an early stop fouls.
    cyc(1);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    chk("wait_start_ignored", obs(), exp_out(0, 0, 4'h0, 0));
    r = int'($urandom_range(3, 40));
    cyc(r);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk("foul_entry", obs(), exp_out(0, 1, 4'hF, 0));
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    cyc(1);
    chk("foul_stop_ignored", obs(), exp_out(0, 1, 4'hF, 0));

    // Round C: start out of FOUL, run to saturation.
    bus.start = 1'b1;
    d = delay_of(model_lfsr);
    cyc(1);
    bus.start = 1'b0;
    chk("foul_to_wait", obs(), exp_out(0, 0, 4'h0, 0));
    wait_led(d, n);
    r = int'($urandom_range(401, 39000));
    for (int k = 1; k <= 40000; k++) begin
      cyc(1);
      if (k == 36 || k == 40 || k == 396 || k == 400 || k == r || k == 39999)
        chk("sat_count", obs(), exp_out(1, 0, 4'hF, k / int'(TickDiv)));
    end
    chk("sat_done", obs(), exp_out(0, 0, 4'hF, 9999));
    cyc(9);
    chk("sat_hold", obs(), exp_out(0, 0, 4'hF, 9999));

    // Round D: reset in the middle of GO at count 0123.
    bus.start = 1'b1;
    d = delay_of(model_lfsr);
    cyc(1);
    bus.start = 1'b0;
    chk("d_wait_entry", obs(), exp_out(0, 0, 4'h0, 0));
    wait_led(d, n);
    cyc(493);
    chk("d_count_0123", obs(), exp_out(1, 0, 4'hF, 123));
    #3 reset = 1'b1;
    #1;
    chk("reset_mid_go", obs(), exp_out(0, 0, 4'hF, 0));

    // Round E: same release timing as round A, so the wait must repeat.
    bus.start = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    bus.start = 1'b0;
    chk("e_wait_entry", obs(), exp_out(0, 0, 4'h0, 0));
    wait_led(d1, n);

    // Stop edge landing exactly on a tick: that tick is not counted.
    s = 4 * int'($urandom_range(2, 100));
    stop_at(s);
    chk("e_stop_on_tick", obs(), exp_out(0, 0, 4'hF, cnt_at_stop(s)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
